// File: rtl/aes_avalon_host_driver.sv
// aes_avalon_host_driver: Avalon-MM master that loads key/plaintext into the AES
//   slave, sets START, polls DONE, and reads back the ciphertext.
// Latency: done pulses 17 cycles after the start cycle when there are no stalls
//   and DONE reads 1 on the first poll. Longer with stalls, polls and gaps.
// Backpressure: every transfer holds address/data/strobes while avm_waitrequest
//   is high. start is ignored while busy, including the done cycle.
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   start              : one-cycle request, key_in/text_in captured when accepted
//   busy/done          : busy from accepted start through the done pulse
//   result/error       : ciphertext and timeout flag, valid from done
//   avm_*              : Avalon-MM master (zero read latency, waitrequest stalls)
// Optional feature: define AES_DRV_TIMEOUT_EN to bound DONE polling at POLL_MAX
//   reads. When it is not defined, polling is unbounded and error is tied 0.
module aes_avalon_host_driver #(
  parameter int POLL_MAX = 1024,
  parameter int POLL_GAP = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [127:0] text_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] result,
  output logic         error,
  output logic [3:0]   avm_address,
  output logic         avm_read,
  output logic         avm_write,
  output logic [31:0]  avm_writedata,
  output logic [3:0]   avm_byteenable,
  input  logic [31:0]  avm_readdata,
  input  logic         avm_waitrequest
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_KEY,
    S_WR_TEXT,
    S_SET_GO,
    S_POLL,
    S_GAP,
    S_RD_CT,
    S_CLR_GO,
    S_FIN
  } state_t;

  localparam logic [3:0]  ADDR_GO   = 4'd14;
  localparam logic [3:0]  ADDR_DONE = 4'd15;
  // Last value of the gap counter before returning to POLL.
  localparam logic [15:0] GAP_LAST  = 16'((POLL_GAP > 0) ? (POLL_GAP - 1) : 0);

  state_t         state_q, state_d;
  logic [1:0]     wcnt_q, wcnt_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   text_q, text_d;
  logic [95:0]    ct_buf_q, ct_buf_d;
  logic [127:0]   result_q, result_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [15:0]    gap_cnt_q, gap_cnt_d;

`ifdef AES_DRV_TIMEOUT_EN
  localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);
  logic [15:0]    poll_cnt_q, poll_cnt_d;
  logic           to_q, to_d;
  logic           error_q, error_d;
  logic [15:0]    poll_inc;

  assign poll_inc = poll_cnt_q + 16'd1;
`endif

  // Word 0 of a 128-bit block is the most significant 32 bits.
  function automatic logic [31:0] word_sel(input logic [127:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    word_sel = v[127:96];
      2'd1:    word_sel = v[95:64];
      2'd2:    word_sel = v[63:32];
      default: word_sel = v[31:0];
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    key_d         = key_q;
    text_d        = text_q;
    ct_buf_d      = ct_buf_q;
    result_d      = result_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    gap_cnt_d     = gap_cnt_q;
`ifdef AES_DRV_TIMEOUT_EN
    poll_cnt_d    = poll_cnt_q;
    to_d          = to_q;
    error_d       = error_q;
`endif
    avm_address   = 4'd0;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_writedata = 32'd0;

    // busy stays high through the done cycle, then drops.
    if (done_q) begin
      busy_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        // busy_q is still high in the done cycle, which blocks a start there.
        if (start && !busy_q) begin
          key_d   = key_in;
          text_d  = text_in;
          busy_d  = 1'b1;
          wcnt_d  = 2'd0;
          state_d = S_WR_KEY;
`ifdef AES_DRV_TIMEOUT_EN
          error_d = 1'b0;
          to_d    = 1'b0;
`endif
        end
      end

      S_WR_KEY: begin
        avm_write     = 1'b1;
        avm_address   = {2'b00, wcnt_q};
        avm_writedata = word_sel(key_q, wcnt_q);
        if (!avm_waitrequest) begin
          wcnt_d = wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) begin
            state_d = S_WR_TEXT;
          end
        end
      end

      S_WR_TEXT: begin
        avm_write     = 1'b1;
        avm_address   = {2'b01, wcnt_q};
        avm_writedata = word_sel(text_q, wcnt_q);
        if (!avm_waitrequest) begin
          wcnt_d = wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) begin
            state_d = S_SET_GO;
          end
        end
      end

      S_SET_GO: begin
        avm_write     = 1'b1;
        avm_address   = ADDR_GO;
        avm_writedata = 32'd1;
        if (!avm_waitrequest) begin
          state_d = S_POLL;
`ifdef AES_DRV_TIMEOUT_EN
          poll_cnt_d = 16'd0;
`endif
        end
      end

      S_POLL: begin
        avm_read    = 1'b1;
        avm_address = ADDR_DONE;
        if (!avm_waitrequest) begin
          if (avm_readdata[0]) begin
            state_d = S_RD_CT;
          end else begin
`ifdef AES_DRV_TIMEOUT_EN
            poll_cnt_d = poll_inc;
`endif
            if (POLL_GAP == 0) begin
              state_d = S_POLL;
            end else begin
              gap_cnt_d = 16'd0;
              state_d   = S_GAP;
            end
`ifdef AES_DRV_TIMEOUT_EN
            // Give up: skip the ciphertext reads but still clear START.
            if (poll_inc >= POLL_LIMIT) begin
              to_d    = 1'b1;
              state_d = S_CLR_GO;
            end
`endif
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_POLL;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end

      S_RD_CT: begin
        avm_read    = 1'b1;
        avm_address = {2'b10, wcnt_q};
        if (!avm_waitrequest) begin
          wcnt_d = wcnt_q + 2'd1;
          // Earlier words wait in ct_buf so result changes in one step.
          if (wcnt_q == 2'd3) begin
            result_d = {ct_buf_q, avm_readdata};
            state_d  = S_CLR_GO;
          end else begin
            ct_buf_d = {ct_buf_q[63:0], avm_readdata};
          end
        end
      end

      S_CLR_GO: begin
        avm_write     = 1'b1;
        avm_address   = ADDR_GO;
        avm_writedata = 32'd0;
        if (!avm_waitrequest) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
`ifdef AES_DRV_TIMEOUT_EN
        if (to_q) begin
          error_d  = 1'b1;
          result_d = 128'd0;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wcnt_q     <= 2'd0;
      key_q      <= 128'd0;
      text_q     <= 128'd0;
      ct_buf_q   <= 96'd0;
      result_q   <= 128'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      gap_cnt_q  <= 16'd0;
`ifdef AES_DRV_TIMEOUT_EN
      poll_cnt_q <= 16'd0;
      to_q       <= 1'b0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      key_q      <= key_d;
      text_q     <= text_d;
      ct_buf_q   <= ct_buf_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      gap_cnt_q  <= gap_cnt_d;
`ifdef AES_DRV_TIMEOUT_EN
      poll_cnt_q <= poll_cnt_d;
      to_q       <= to_d;
      error_q    <= error_d;
`endif
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign result         = result_q;
  assign avm_byteenable = {4{avm_read | avm_write}};

`ifdef AES_DRV_TIMEOUT_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: doc/aes_avalon_host_driver.md
Name: aes_avalon_host_driver

Overview:
Avalon-MM master that drives the AES Avalon slave register block from plain RTL, so no Nios II software is needed. Takes a 128-bit key and plaintext on a start strobe, writes both into the slave, sets START, polls DONE, reads back the 128-bit ciphertext and returns it with a done pulse. Sits beside the AES interface in subsystem B and acts as its hardware initiator for bring-up and throughput tests.

Parameters:
POLL_MAX, 1024, maximum DONE-register reads before timeout (used only with the optional feature)
POLL_GAP, 4, idle cycles between successive DONE polls (0 = back-to-back)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
key_in  in  128  AES key, captured on accepted start
text_in  in  128  plaintext, captured on accepted start
busy  out  1  high from accepted start until done pulse, inclusive
done  out  1  one-cycle completion pulse
result  out  128  ciphertext; valid from done, held until next accepted start
error  out  1  timeout flag; valid with done, held until next accepted start
avm_address  out  4  word address into the slave
avm_read  out  1  Avalon read
avm_write  out  1  Avalon write
avm_writedata  out  32  write data
avm_byteenable  out  4  always 4'hF while read or write is high, else 0
avm_readdata  in  32  read data, valid in the cycle read is high and waitrequest is low
avm_waitrequest  in  1  slave stall

Behaviour:
- Clock and reset: single clock `clk`; reset is synchronous and active-high. All outputs are 0 on the first edge where reset is sampled high: busy, done, error, result, avm_* all 0, FSM in IDLE.
- Slave map, word addresses: 0-3 key, 4-7 plaintext, 8-11 ciphertext, 14 START (bit0), 15 DONE (bit0). Word 0/4/8 holds bits [127:96] (MSW first). Offsets +1..+3 descend to bits [31:0].
- Avalon rules:
  - At most one of read/write is high at a time.
  - address, writedata and byteenable stay stable while waitrequest is high.
  - A transfer completes on the first edge with waitrequest low.
  - Read data is captured on that same edge (zero read latency).
  - The next transfer may start in the following cycle.
- FSM:
  - IDLE: start=1 captures key_in/text_in, busy goes high next cycle, clears error, enters WR_KEY.
  - WR_KEY: 4 writes, addr 0..3. Then WR_TEXT.
  - WR_TEXT: 4 writes, addr 4..7. Then SET_GO.
  - SET_GO: write 1 to addr 14. Then POLL.
  - POLL: read addr 15.
    - bit0=1 goes to RD_CT.
    - bit0=0 goes to GAP for POLL_GAP cycles (no bus activity), then back to POLL. POLL_GAP=0 polls back-to-back.
  - RD_CT: 4 reads, addr 8..11, into result[127:96]..[31:0]. Then CLR_GO.
  - CLR_GO: write 0 to addr 14. Then FIN.
  - FIN: done=1 for one cycle, busy drops in the following cycle, returns to IDLE.
- Word counter is 2 bits and wraps 3->0 on each phase change. It advances only on completed transfers.
- start while busy is ignored, with no queuing. start in the same cycle as the done pulse is also ignored.
- result does not change until the last ciphertext word completes. On the done edge all 128 bits are consistent.
- Minimum latency with waitrequest held low and DONE already 1 on the first poll: 4+4+1+1+4+1 = 15 bus cycles, plus 1 for FIN. done asserts 17 cycles after the start cycle.
- Reset mid-transaction: read/write deassert on the reset edge and any in-flight transfer is abandoned. The slave is not cleaned up.
- avm_readdata is ignored except on completed reads.

Optional Feature:
- Macro: AES_DRV_TIMEOUT_EN.
- When defined:
  - A 16-bit poll counter resets on entering POLL from SET_GO and increments on each completed DONE read returning 0.
  - When the count reaches POLL_MAX, the FSM skips RD_CT and goes to CLR_GO.
  - On the done pulse error=1 and result=0.
- When undefined: no counter, polling is unbounded, and error is tied 0.

Test Plan:
1. FIPS-197 C.1 vector. Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, slave model returns ct 69c4e0d86a7b0430d8cdb78070b4c55a, waitrequest=0, DONE=1 on first poll. Required: write sequence addr 0..7 with words 00010203.. and 00112233.. in order, then 14<-1, read 15, reads 8..11, 14<-0; done 17 cycles after start; result=69c4e0d8..c55a; error=0.
2. Random waitrequest, 50% high. Required: no addr/data change while stalled, same transfer order as scenario 1, identical result.
3. DONE returns 0 for 5 polls with POLL_GAP=4. Required: exactly 6 reads of addr 15, 4 idle cycles between consecutive polls, then normal completion.
4. start pulsed during busy, and again in the done cycle. Required: both ignored; one transaction only; key/text are those from the first accepted start.
5. reset asserted mid-WR_TEXT while waitrequest=1. Required: read/write/busy/done all 0 on the next edge. A subsequent start runs a full clean sequence from addr 0.
6. With AES_DRV_TIMEOUT_EN defined, POLL_MAX=8, DONE always 0. Required: 8 polls, no addr 8..11 reads, 14<-0 written, done with error=1 and result=0. With the macro undefined, polling is still running after 1000 cycles.
